// File: rtl/note_pkg.sv
// Shared constants and types for the note highway.
//   ROWS / ADDR_W  : default highway depth and chart ROM address width
//   chart word     : lanes in [15:12], delay in [11:0], 16'h0000 ends the chart
//   state_e        : playback FSM states
package note_pkg;

  localparam int unsigned ROWS    = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned DELAY_W = 12;

  localparam int unsigned LANES_MSB = 15;
  localparam int unsigned LANES_LSB = 12;
  localparam int unsigned DELAY_MSB = 11;
  localparam int unsigned DELAY_LSB = 0;

  localparam logic [WORD_W-1:0] END_MARKER = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tick_edge.sv
// Game-tick detector: one-clock pulse on each gameclk rising edge.
//   clock, reset : clock and synchronous active-high reset
//   gameclk_i    : game-tick level, synchronous to clock
//   tick_c       : combinational pulse, high while gameclk is 1 and last sample was 0
module tick_edge (
  input  logic clock,
  input  logic reset,
  input  logic gameclk_i,
  output logic tick_c
);

  logic sample_q;

  // One-clock registered sample of the level
  always_ff @(posedge clock) begin
    if (reset) sample_q <= 1'b0;
    else       sample_q <= gameclk_i;
  end

  assign tick_c = gameclk_i & ~sample_q;

endmodule

// File: rtl/note_highway.sv
// Note highway: plays a chart from ROM into a scrolling array of lane rows.
//   clock, reset   : clock and synchronous active-high reset
//   gameclk        : game-tick level; each rising edge scrolls the highway
//   start          : pulse in IDLE begins chart playback
//   hit            : per-lane clear of row 0 (ignored on a tick cycle)
//   chart_addr     : chart ROM address; chart_data returns one clock later
//   intersections  : row 0 occupancy
//   highway        : all rows, row r at bits [4r+3:4r]
//   miss           : pulse when a non-empty row 0 scrolls off
//   busy / done    : not IDLE / DONE with an empty highway
module note_highway
  import note_pkg::*;
#(
  parameter int unsigned ROWS   = note_pkg::ROWS,
  parameter int unsigned ADDR_W = note_pkg::ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  gameclk,
  input  logic                  start,
  input  logic [LANES-1:0]      hit,
  output logic [ADDR_W-1:0]     chart_addr,
  input  logic [WORD_W-1:0]     chart_data,
  output logic [LANES-1:0]      intersections,
  output logic [LANES*ROWS-1:0] highway,
  output logic                  miss,
  output logic                  busy,
  output logic                  done
);

  logic                       tick_c;
  state_e                     state_q, state_d;
  logic [ROWS-1:0][LANES-1:0] rows_q, rows_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [LANES-1:0]           pend_lanes_q, pend_lanes_d;
  logic [DELAY_W-1:0]         pend_cnt_q, pend_cnt_d;
  logic                       tick_pend_q, tick_pend_d;
  logic                       miss_q, miss_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  tick_edge u_tick_edge (
    .clock     (clock),
    .reset     (reset),
    .gameclk_i (gameclk),
    .tick_c    (tick_c)
  );

  // Next-state: scrolling, hit clearing, chart walk and spawn countdown
  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    addr_d       = addr_q;
    pend_lanes_d = pend_lanes_q;
    pend_cnt_d   = pend_cnt_q;
    tick_pend_d  = tick_pend_q;
    miss_d       = 1'b0;

    // A tick outside IDLE always shifts with an empty spawn; WAIT may overwrite the spawn row
    if (tick_c && (state_q != S_IDLE)) begin
      miss_d = |rows_q[0];
      for (int unsigned r = 0; r < ROWS - 1; r++) begin
        rows_d[r] = rows_q[r+1];
      end
      rows_d[ROWS-1] = '0;
    end else begin
      rows_d[0] = rows_q[0] & ~hit;
    end

    case (state_q)
      S_IDLE: begin
        addr_d      = '0;
        tick_pend_d = 1'b0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (tick_c) tick_pend_d = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (tick_c) tick_pend_d = 1'b1;
        pend_lanes_d = chart_data[LANES_MSB:LANES_LSB];
        pend_cnt_d   = chart_data[DELAY_MSB:DELAY_LSB];
        addr_d       = ADDR_W'(addr_q + 1'b1);
        state_d      = (chart_data == END_MARKER) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        // A tick seen during FETCH/LOAD already shifted rows; here it only counts down
        if (tick_c || tick_pend_q) begin
          tick_pend_d = 1'b0;
          if (pend_cnt_q == '0) begin
            rows_d[ROWS-1] = pend_lanes_q;
            state_d        = S_FETCH;
          end else begin
            pend_cnt_d = DELAY_W'(pend_cnt_q - 1'b1);
          end
        end
      end
      S_DONE: begin
        tick_pend_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) && (rows_d == '0);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rows_q       <= '0;
      addr_q       <= '0;
      pend_lanes_q <= '0;
      pend_cnt_q   <= '0;
      tick_pend_q  <= 1'b0;
      miss_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      addr_q       <= addr_d;
      pend_lanes_q <= pend_lanes_d;
      pend_cnt_q   <= pend_cnt_d;
      tick_pend_q  <= tick_pend_d;
      miss_q       <= miss_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign chart_addr    = addr_q;
  assign intersections = rows_q[0];
  assign highway       = rows_q;
  assign miss          = miss_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
